uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single rs232out transmitter between NREQ byte-stream requesters, e.g. the yarvi_soc console and a debug/status source.
- Round-robin arbitration with a per-owner lock, so that bursts from one requester are not interleaved byte-by-byte with another's.
- Sits between the requesters and the tx_data_valid/tx_data_ready/tx_data handshake of rs232out.
- One-entry registered output stage.

Parameters:
- NREQ, 2: number of requesters (2..8).
- MAX_BURST, 16: maximum number of bytes granted per lock (>=1).
- IDLE_TIMEOUT, 1024: number of consecutive owner-idle cycles that forces a release (>=1).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester byte valid.
- req_ready  output  NREQ  per-requester accept.
- req_data  input  8*NREQ  requester i byte at bits [8i+7:8i].
- out_valid  output  1  byte available to the transmitter.
- out_ready  input  1  transmitter accepts.
- out_data  output  8  byte to the transmitter.
- grant  output  NREQ  one-hot current owner; all zero when no owner.
- busy  output  1  lock held or out_valid set.

Behaviour:
- Reset is asynchronous and active-high. It clears all state immediately:
  - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, idle_cnt=0.
  - out_valid=0, out_data=0.
  - A byte in flight in the output register is discarded.
- Output register:
  - space = !out_valid || out_ready.
  - Load when an owner transfer occurs: out_data<=byte, out_valid<=1.
  - Otherwise, if out_ready, out_valid<=0.
  - Simultaneous drain and load sustains 1 byte/cycle.
- IDLE state:
  - All req_ready=0.
  - Search from rr_ptr upward, modulo NREQ, for the first requester with req_valid=1.
  - If one is found: owner<=i, grant<=onehot(i), burst_cnt<=0, idle_cnt<=0, state<=LOCKED.
  - Arbitration costs exactly 1 cycle; no byte moves in the cycle of the IDLE decision.
  - If none is found, stay in IDLE.
- LOCKED state:
  - req_ready[owner]=space. Every non-owner req_ready=0.
  - Transfer = req_valid[owner] && req_ready[owner].
  - On transfer: burst_cnt++ and idle_cnt<=0.
  - When req_valid[owner]=0: idle_cnt++ (saturating).
  - When req_valid[owner]=1 but space=0 (backpressure), idle_cnt holds; backpressure is not idleness.
- Release (LOCKED -> IDLE, takes effect the next cycle):
  - Triggers: a transfer brings burst_cnt to MAX_BURST, or idle_cnt reaches IDLE_TIMEOUT.
  - On release: rr_ptr<=(owner+1) mod NREQ, grant<=0.
  - If a transfer and the timeout would coincide, the transfer wins: the byte is taken and idle_cnt resets.
- Fairness: with every requester continuously valid, the owners cycle 0,1,...,NREQ-1,0. Each gets MAX_BURST bytes followed by 1 arbitration bubble.
- The output register drains independently of state; a release never drops the byte in out_data.
- grant is registered and changes only on acquire and release.
- busy = (state==LOCKED) || out_valid.
- Counters:
  - burst_cnt width is clog2(MAX_BURST+1).
  - idle_cnt width is clog2(IDLE_TIMEOUT+1); it saturates and never wraps.

Optional Feature:
- Macro: UART_TX_ARB_LINE_LOCK_EN.
- When defined: a transfer of byte 8'h0A ('\n') also releases the lock, with the same timing as a MAX_BURST release, so whole text lines stay atomic up to MAX_BURST. The burst limit and timeout still apply.
- When undefined: byte values never affect arbitration; only MAX_BURST and IDLE_TIMEOUT release the lock.

Test Plan:
- Reset, then drive req_valid=2'b01 with bytes 0x41..0x43 and out_ready=1:
  - grant=01 one cycle after req_valid rises.
  - out_data shows 41,42,43 on consecutive cycles.
  - After 1024 idle cycles grant=00 and rr_ptr=1.
- NREQ=2, MAX_BURST=4, both requesters always valid (R0 streams 0x00.., R1 streams 0x80..), out_ready=1:
  - Output is 00,01,02,03, then a 1-cycle bubble, then 80,81,82,83, then a bubble, then 04..07.
- Hold out_ready=0 for 50 cycles while the owner is valid:
  - out_valid=1 and out_data is held stable.
  - req_ready[owner]=0 and idle_cnt stays 0.
  - No release occurs, even with IDLE_TIMEOUT=8.
- Assert reset for 1 cycle mid-burst with out_valid=1:
  - out_valid=0, grant=0 and req_ready=0 immediately (asynchronous).
  - The next acquire searches from requester 0.
- With UART_TX_ARB_LINE_LOCK_EN, R0 sends "hi\n" and R1 is valid:
  - Output is 68,69,0A, then a bubble, then R1's bytes.
  - Without the macro, R0 keeps the grant until MAX_BURST or the timeout.
- Owner holds req_valid=0 for exactly IDLE_TIMEOUT-1 cycles, then sends a byte:
  - No release; the byte is transferred and idle_cnt returns to 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locking arbiter that feeds one rs232out transmitter.
// Define UART_TX_ARB_LINE_LOCK_EN to also release the lock after a '\n' byte.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int PW  = $clog2(NREQ);
  localparam int PW1 = PW + 1;
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int IW  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] r_grant;
  logic [BW-1:0]   r_burst_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_out_valid;
  logic [7:0]      r_out_data;

  logic            w_space;
  logic            w_locked;
  logic            w_own_valid;
  logic [7:0]      w_own_data;
  logic            w_xfer;
  logic            w_burst_rel;
  logic            w_line_rel;
  logic            w_idle_rel;
  logic            w_release;
  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic [PW:0]     v_sum;

  assign w_space     = !r_out_valid || out_ready;
  assign w_locked    = (r_state == S_LOCKED);
  assign w_own_valid = req_valid[r_owner];
  assign w_own_data  = req_data[{r_owner, 3'b000} +: 8];
  assign w_xfer      = w_locked && w_own_valid && w_space;
  assign w_burst_rel = w_xfer && (r_burst_cnt == BW'(MAX_BURST - 1));
  assign w_idle_rel  = w_locked && !w_xfer
                       && (r_idle_cnt == IW'(IDLE_TIMEOUT));
  assign w_release   = w_burst_rel || w_line_rel || w_idle_rel;

`ifdef UART_TX_ARB_LINE_LOCK_EN
  assign w_line_rel = w_xfer && (w_own_data == 8'h0A);
`else
  assign w_line_rel = 1'b0;
`endif

  // Lowest rotated offset from rr_ptr wins, so scan offsets high to low.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    v_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + PW1'(k);
      if (v_sum >= PW1'(NREQ))
        v_sum = v_sum - PW1'(NREQ);
      if (req_valid[v_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = v_sum[PW-1:0];
      end
    end
  end

  assign req_ready = (w_locked && w_space) ? r_grant : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign grant     = r_grant;
  assign busy      = w_locked || r_out_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_own_data;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner     <= w_pick;
            r_grant     <= NREQ'(1) << w_pick;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
            r_state     <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
            r_idle_cnt  <= '0;
          end else if (!w_own_valid
                       && r_idle_cnt != IW'(IDLE_TIMEOUT)) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
          if (w_release) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= (r_owner == PW'(NREQ - 1))
                        ? '0 : r_owner + PW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
